// File: rtl/floppy_pkg.sv
// floppy_pkg
// Shared definitions for the floppy-drive voice allocator: default setpoint
// width, note/age/index widths and the allocator FSM state encoding.
package floppy_pkg;

  localparam int SP_WIDTH   = 22;
  localparam int NOTE_WIDTH = 7;
  localparam int AGE_WIDTH  = 8;
  // Wide enough to index up to four voices
  localparam int IDX_WIDTH  = 2;
  localparam int CNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/voice_slot.sv
// voice_slot
// Storage for one floppy voice: enable, note number, step-period setpoint and
// age (note-ons seen since this voice was last (re)triggered, saturating).
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   clr                 panic: clear enable and age (note/setpoint kept)
//   load                start or retrigger this voice with note_in/setp_in
//   off                 disable this voice (setpoint kept)
//   age_inc             age this voice by one if it is sounding
//   note_in, setp_in    values written by load
//   en, note, setp, age current slot contents
module voice_slot
  import floppy_pkg::*;
#(
  parameter int SETP_W = floppy_pkg::SP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  off,
  input  logic                  age_inc,
  input  logic [NOTE_WIDTH-1:0] note_in,
  input  logic [SETP_W-1:0]     setp_in,
  output logic                  en,
  output logic [NOTE_WIDTH-1:0] note,
  output logic [SETP_W-1:0]     setp,
  output logic [AGE_WIDTH-1:0]  age
);

  logic                  en_q, en_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [SETP_W-1:0]     setp_q, setp_d;
  logic [AGE_WIDTH-1:0]  age_q, age_d;

  // Panic outranks a load; age only advances on a sounding voice and sticks at max
  always_comb begin
    en_d   = en_q;
    note_d = note_q;
    setp_d = setp_q;
    age_d  = age_q;
    if (clr) begin
      en_d  = 1'b0;
      age_d = '0;
    end else if (load) begin
      en_d   = 1'b1;
      note_d = note_in;
      setp_d = setp_in;
      age_d  = '0;
    end else begin
      if (off) begin
        en_d = 1'b0;
      end
      if (age_inc && en_q && (age_q != '1)) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      note_q <= '0;
      setp_q <= '0;
      age_q  <= '0;
    end else begin
      en_q   <= en_d;
      note_q <= note_d;
      setp_q <= setp_d;
      age_q  <= age_d;
    end
  end

  assign en   = en_q;
  assign note = note_q;
  assign setp = setp_q;
  assign age  = age_q;

endmodule

// File: rtl/floppy_voice_alloc.sv
// floppy_voice_alloc
// Allocates MIDI note-on/off events onto NUM_VOICES floppy drives. An accepted
// event is scanned against one voice per cycle, then committed in one cycle:
// retrigger a voice already holding the note, else take the lowest free voice,
// else steal the oldest. Note-off releases every voice holding the note.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   ev_valid/ev_ready      event handshake (ready only while idle)
//   ev_on, ev_note         note-on (1) / note-off (0) and MIDI note
//   ev_period              setpoint for note-on; zero is rejected via err
//   all_off                synchronous panic, silences everything
//   v_en, v_setp           per-floppy enable and setpoint (slice i = voice i)
//   active_cnt             number of sounding voices
//   steal, err             one-cycle pulses reporting eviction / rejection
module floppy_voice_alloc
  import floppy_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int SP_WIDTH   = floppy_pkg::SP_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [NOTE_WIDTH-1:0]          ev_note,
  input  logic [SP_WIDTH-1:0]            ev_period,
  input  logic                           all_off,
  output logic [NUM_VOICES-1:0]          v_en,
  output logic [NUM_VOICES*SP_WIDTH-1:0] v_setp,
  output logic [CNT_WIDTH-1:0]           active_cnt,
  output logic                           steal,
  output logic                           err
);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  lat_on_q, lat_on_d;
  logic [NOTE_WIDTH-1:0] lat_note_q, lat_note_d;
  logic [SP_WIDTH-1:0]   lat_period_q, lat_period_d;
  logic [NUM_VOICES-1:0] match_q, match_d;
  logic                  free_found_q, free_found_d;
  logic [IDX_WIDTH-1:0]  free_idx_q, free_idx_d;
  logic [IDX_WIDTH-1:0]  old_idx_q, old_idx_d;
  logic [AGE_WIDTH-1:0]  old_age_q, old_age_d;
  logic                  steal_q, steal_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  clr;
  logic [NUM_VOICES-1:0] load;
  logic [NUM_VOICES-1:0] off;
  logic [NUM_VOICES-1:0] age_inc;
  logic [IDX_WIDTH-1:0]  match_lo;
  logic [IDX_WIDTH-1:0]  tgt;
  logic [NUM_VOICES-1:0] en_next;

  logic [NUM_VOICES-1:0] en_w;
  logic [NOTE_WIDTH-1:0] note_w [NUM_VOICES];
  logic [SP_WIDTH-1:0]   setp_w [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  age_w  [NUM_VOICES];

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot #(
      .SETP_W (SP_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (load[g]),
      .off     (off[g]),
      .age_inc (age_inc[g]),
      .note_in (lat_note_q),
      .setp_in (lat_period_q),
      .en      (en_w[g]),
      .note    (note_w[g]),
      .setp    (setp_w[g]),
      .age     (age_w[g])
    );
    assign v_setp[g*SP_WIDTH +: SP_WIDTH] = setp_w[g];
  end

  // Lowest-index voice flagged as holding the latched note
  always_comb begin
    match_lo = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        match_lo = IDX_WIDTH'(i);
      end
    end
  end

  // Scan accumulates match/free/oldest results one voice per cycle; voice 0
  // seeds the free and oldest trackers so no clearing step is needed.
  // all_off is applied last so it overrides any commit in the same cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_on_d     = lat_on_q;
    lat_note_d   = lat_note_q;
    lat_period_d = lat_period_q;
    match_d      = match_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    old_idx_d    = old_idx_q;
    old_age_d    = old_age_q;
    steal_d      = 1'b0;
    err_d        = 1'b0;
    clr          = 1'b0;
    load         = '0;
    off          = '0;
    age_inc      = '0;
    tgt          = '0;

    case (state_q)
      IDLE: begin
        if (ev_valid && ready_q) begin
          lat_on_d     = ev_on;
          lat_note_d   = ev_note;
          lat_period_d = ev_period;
          idx_d        = '0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (idx_q == IDX_WIDTH'(i)) begin
            match_d[i] = en_w[i] && (note_w[i] == lat_note_q);
            if (i == 0) begin
              free_found_d = !en_w[i];
              free_idx_d   = '0;
              old_idx_d    = '0;
              old_age_d    = age_w[i];
            end else begin
              if (!en_w[i] && !free_found_q) begin
                free_found_d = 1'b1;
                free_idx_d   = IDX_WIDTH'(i);
              end
              // Strictly greater keeps ties on the lower index
              if (age_w[i] > old_age_q) begin
                old_idx_d = IDX_WIDTH'(i);
                old_age_d = age_w[i];
              end
            end
          end
        end
        if (idx_q == IDX_WIDTH'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (lat_on_q) begin
          if (lat_period_q == '0) begin
            err_d = 1'b1;
          end else begin
            if (|match_q) begin
              tgt = match_lo;
            end else if (free_found_q) begin
              tgt = free_idx_q;
            end else begin
              tgt     = old_idx_q;
              steal_d = 1'b1;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (tgt == IDX_WIDTH'(i)) begin
                load[i] = 1'b1;
              end else begin
                age_inc[i] = 1'b1;
              end
            end
          end
        end else begin
          off = match_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (all_off) begin
      state_d = IDLE;
      clr     = 1'b1;
      load    = '0;
      off     = '0;
      age_inc = '0;
      steal_d = 1'b0;
      err_d   = 1'b0;
    end

    ready_d = (state_d == IDLE);
  end

  // Predict next enables exactly as the slots will, so the registered count
  // changes on the same edge as v_en
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      en_next[i] = clr ? 1'b0 : (load[i] ? 1'b1 : (off[i] ? 1'b0 : en_w[i]));
      cnt_d = cnt_d + {{(CNT_WIDTH-1){1'b0}}, en_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ready_q      <= 1'b0;
      lat_on_q     <= 1'b0;
      lat_note_q   <= '0;
      lat_period_q <= '0;
      match_q      <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      steal_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ready_q      <= ready_d;
      lat_on_q     <= lat_on_d;
      lat_note_q   <= lat_note_d;
      lat_period_q <= lat_period_d;
      match_q      <= match_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      old_idx_q    <= old_idx_d;
      old_age_q    <= old_age_d;
      steal_q      <= steal_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ev_ready   = ready_q;
  assign v_en       = en_w;
  assign active_cnt = cnt_q;
  assign steal      = steal_q;
  assign err        = err_q;

endmodule

// File: tb/tb_floppy_voice_alloc.sv
// tb_floppy_voice_alloc
// Self-checking bench: each event updates a behavioural voice model and pushes
// the expected outputs to a queue; the entry is popped and compared when the
// allocator commits.
module tb_floppy_voice_alloc;

  localparam int NV  = 2;
  localparam int SPW = 22;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_on = 1'b0;
  logic [6:0]        ev_note = '0;
  logic [SPW-1:0]    ev_period = '0;
  logic              all_off = 1'b0;
  logic [NV-1:0]     v_en;
  logic [NV*SPW-1:0] v_setp;
  logic [2:0]        active_cnt;
  logic              steal;
  logic              err;

  floppy_voice_alloc #(
    .NUM_VOICES (NV),
    .SP_WIDTH   (SPW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .ev_period  (ev_period),
    .all_off    (all_off),
    .v_en       (v_en),
    .v_setp     (v_setp),
    .active_cnt (active_cnt),
    .steal      (steal),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NV-1:0]     en;
    logic [NV*SPW-1:0] setp;
    logic [2:0]        cnt;
    logic              steal;
    logic              err;
  } exp_t;

  exp_t           sbQueue[$];
  logic           mEn   [NV];
  logic [6:0]     mNote [NV];
  logic [SPW-1:0] mSetp [NV];
  int             mAge  [NV];
  int             checkCount = 0;
  int             passCount = 0;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t modelSnapshot(input logic st, input logic er);
    exp_t e;
    e.en = '0;
    e.setp = '0;
    e.cnt = '0;
    e.steal = st;
    e.err = er;
    for (int i = 0; i < NV; i++) begin
      e.en[i] = mEn[i];
      e.setp[i*SPW +: SPW] = mSetp[i];
      e.cnt = e.cnt + {2'b00, mEn[i]};
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NV; i++) begin
      mEn[i] = 1'b0;
      mNote[i] = '0;
      mSetp[i] = '0;
      mAge[i] = 0;
    end
  endtask

  task automatic modelAllOff();
    for (int i = 0; i < NV; i++) begin
      mEn[i] = 1'b0;
      mAge[i] = 0;
    end
  endtask

  // Behavioural allocation: retrigger, else lowest free, else oldest (ties low)
  task automatic modelEvent(input logic on, input logic [6:0] note, input logic [SPW-1:0] period,
                            output exp_t e);
    int  tgt;
    logic st;
    logic er;
    st = 1'b0;
    er = 1'b0;
    if (on) begin
      if (period == 0) begin
        er = 1'b1;
      end else begin
        tgt = -1;
        for (int i = 0; i < NV; i++)
          if (tgt < 0 && mEn[i] && mNote[i] == note) tgt = i;
        for (int i = 0; i < NV; i++)
          if (tgt < 0 && !mEn[i]) tgt = i;
        if (tgt < 0) begin
          tgt = 0;
          for (int i = 1; i < NV; i++)
            if (mAge[i] > mAge[tgt]) tgt = i;
          st = 1'b1;
        end
        for (int i = 0; i < NV; i++)
          if (i != tgt && mEn[i] && mAge[i] < 255) mAge[i]++;
        mEn[tgt] = 1'b1;
        mNote[tgt] = note;
        mSetp[tgt] = period;
        mAge[tgt] = 0;
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (mEn[i] && mNote[i] == note) mEn[i] = 1'b0;
    end
    e = modelSnapshot(st, er);
  endtask

  task automatic collectResult(input string tag);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'(sbQueue.size()), 64'd1);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput({tag, "_en"}, 64'(v_en), 64'(e.en));
    checkOutput({tag, "_setp"}, 64'(v_setp), 64'(e.setp));
    checkOutput({tag, "_cnt"}, 64'(active_cnt), 64'(e.cnt));
    checkOutput({tag, "_steal"}, 64'(steal), 64'(e.steal));
    checkOutput({tag, "_err"}, 64'(err), 64'(e.err));
    checkOutput({tag, "_ready"}, 64'(ev_ready), 64'd1);
  endtask

  // Waits (bounded) for ready at a falling edge, then runs one full event
  task automatic applyStimulus(input string tag, input logic on, input logic [6:0] note,
                               input logic [SPW-1:0] period);
    exp_t e;
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ev_ready) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput({tag, "_ready_timeout"}, 64'(ev_ready), 64'd1);
      return;
    end
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = note;
    ev_period = period;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    modelEvent(on, note, period, e);
    sbQueue.push_back(e);
    repeat (NV) @(posedge clk);
    #1;
    checkOutput({tag, "_busy"}, 64'(ev_ready), 64'd0);
    @(posedge clk);
    #1;
    collectResult(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_en", 64'(v_en), 64'd0);
    checkOutput("rst_setp", 64'(v_setp), 64'd0);
    checkOutput("rst_cnt", 64'(active_cnt), 64'd0);
    checkOutput("rst_ready", 64'(ev_ready), 64'd0);
    checkOutput("rst_steal_err", 64'({steal, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_low", 64'(ev_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready_high", 64'(ev_ready), 64'd1);

    // Fill both voices, then steal the oldest
    applyStimulus("s1_on60", 1'b1, 7'd60, 22'd100000);
    applyStimulus("s2_on64", 1'b1, 7'd64, 22'd120000);
    applyStimulus("s2_on67", 1'b1, 7'd67, 22'd90000);
    @(posedge clk);
    #1;
    checkOutput("s2_steal_drop", 64'(steal), 64'd0);

    // Note-off with no match, then a matching note-off
    applyStimulus("s4_off72", 1'b0, 7'd72, 22'd0);
    applyStimulus("s4_off64", 1'b0, 7'd64, 22'd0);

    // Zero period rejected
    applyStimulus("s5_zero", 1'b1, 7'd70, 22'd0);
    @(posedge clk);
    #1;
    checkOutput("s5_err_drop", 64'(err), 64'd0);

    // Panic during scan aborts the in-flight event
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_note = 7'd80;
    ev_period = 22'd1234;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk);
    #1;
    modelAllOff();
    checkOutput("s5_alloff_en", 64'(v_en), 64'd0);
    checkOutput("s5_alloff_ready", 64'(ev_ready), 64'd1);
    checkOutput("s5_alloff_cnt", 64'(active_cnt), 64'd0);
    @(negedge clk);
    all_off = 1'b0;
    repeat (NV + 2) @(posedge clk);
    #1;
    checkOutput("s5_aborted_en", 64'(v_en), 64'd0);
    checkOutput("s5_aborted_setp", 64'(v_setp), 64'(modelSnapshot(1'b0, 1'b0).setp));

    // Retrigger updates the setpoint in place
    applyStimulus("s3_on60", 1'b1, 7'd60, 22'd100000);
    applyStimulus("s3_re60", 1'b1, 7'd60, 22'd50000);

    // Randomised mix over a small note range to exercise ageing and stealing
    for (int k = 0; k < 30; k++) begin
      logic          on;
      logic [6:0]    nt;
      logic [SPW-1:0] pd;
      on = ($urandom_range(0, 3) != 0);
      nt = 7'(60 + $urandom_range(0, 3));
      pd = ($urandom_range(0, 7) == 0) ? '0 : SPW'($urandom_range(1, 4000000));
      applyStimulus($sformatf("rnd%0d", k), on, nt, pd);
    end

    // Reset while the allocator is committing
    @(negedge clk);
    while (!ev_ready) @(negedge clk);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_note = 7'd90;
    ev_period = 22'd777;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    repeat (NV) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("s6_en", 64'(v_en), 64'd0);
    checkOutput("s6_setp", 64'(v_setp), 64'd0);
    checkOutput("s6_cnt", 64'(active_cnt), 64'd0);
    checkOutput("s6_ready", 64'(ev_ready), 64'd0);
    checkOutput("s6_steal_err", 64'({steal, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s6_ready_rise", 64'(ev_ready), 64'd1);
    applyStimulus("s6_after", 1'b1, 7'd60, 22'd100000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/floppy_voice_alloc.md
FLOPPY_VOICE_ALLOC -- requirements
Module: floppy_voice_alloc

Interface
REQ-001 Parameter NUM_VOICES, default 2, is the number of floppy drives/voices; legal range is 2..4.
REQ-002 Parameter SP_WIDTH, default 22, is the step-period setpoint width in clk cycles.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ev_valid  input  1  event request.
REQ-006 ev_ready  output  1  block can accept an event.
REQ-007 ev_on  input  1  1 = note-on, 0 = note-off.
REQ-008 ev_note  input  7  MIDI note number.
REQ-009 ev_period  input  SP_WIDTH  setpoint for note-on; ignored on note-off.
REQ-010 all_off  input  1  synchronous panic; silences all voices.
REQ-011 v_en  output  NUM_VOICES  per-voice enable, one bit per floppy.
REQ-012 v_setp  output  NUM_VOICES*SP_WIDTH  per-voice setpoint, voice i at bits [i*SP_WIDTH +: SP_WIDTH].
REQ-013 active_cnt  output  3  number of set v_en bits.
REQ-014 steal  output  1  one-cycle pulse when a note-on evicts a sounding voice.
REQ-015 err  output  1  one-cycle pulse when a note-on with ev_period == 0 is rejected.

Function
REQ-016 FSM states: IDLE, SCAN, COMMIT; ev_ready shall be 1 only in IDLE.
REQ-017 An event is accepted on the edge where ev_valid && ev_ready; ev_on, ev_note and ev_period are latched on that edge.
REQ-018 SCAN shall examine one voice per cycle, index 0..NUM_VOICES-1, then go to COMMIT; COMMIT lasts one cycle and returns to IDLE.
REQ-019 Outputs shall update on edge E0+NUM_VOICES+1, where E0 is the acceptance edge; ev_ready shall reassert on that same edge.
REQ-020 Note-on when an enabled voice already holds ev_note (retrigger): that voice's setpoint is updated, its age is set to 0, and no other voice is allocated.
REQ-021 Note-on with no match and a free voice: allocate the lowest-index free voice, set its note, setpoint and v_en, and set its age to 0.
REQ-022 Note-on with no match and no free voice: allocate the voice with the largest age (ties to the lowest index) and pulse steal in the COMMIT cycle.
REQ-023 Each committed note-on shall increment the age of every other enabled voice, saturating at 255 (8-bit).
REQ-024 Note-off shall clear v_en of every enabled voice holding ev_note; with no match, nothing changes; v_setp is retained when a voice is disabled.
REQ-025 Note-on with ev_period == 0 shall change no voice state and shall pulse err in COMMIT.
REQ-026 all_off, in any state, shall on the next edge clear all v_en, clear all ages and force IDLE, aborting any in-flight event; all_off has priority over COMMIT.
REQ-027 active_cnt and v_en shall be registered and mutually consistent in every cycle.

Reset
REQ-028 While rst_n is low: state = IDLE, v_en = 0, v_setp = 0, notes = 0, ages = 0, active_cnt = 0, steal = 0, err = 0, ev_ready = 0.
REQ-029 ev_ready shall rise on the first edge after rst_n deasserts.
REQ-030 Assertion of rst_n mid-SCAN or mid-COMMIT shall discard the event with no partial update.

Structure
REQ-031 Shared package floppy_pkg shall hold SP_WIDTH, NOTE_WIDTH = 7, AGE_WIDTH = 8 and the FSM state enum.
REQ-032 Per-voice storage (en, note, setpoint, age) shall be one sub-module, voice_slot, instantiated NUM_VOICES times.
REQ-033 Downstream, v_en[i] and v_setp slice i drive floppy i's enable and setpoint directly.

Verification
REQ-034 Scenario 1 (N = 2): note-on 60/period 100000 accepted at E0 -> v_en = 01, v_setp[0] = 100000 at E0+3, active_cnt = 1.
REQ-035 Scenario 2: note-on 60, then note-on 64 -> v_en = 11; then note-on 67 -> voice 0 (oldest) takes 67, steal pulses once, active_cnt = 2.
REQ-036 Scenario 3: note-on 60 (period 100000), then note-on 60 (period 50000) -> v_en = 01, v_setp[0] = 50000, no steal.
REQ-037 Scenario 4: note-off 72 with voices holding 60/64 -> no change; then note-off 64 -> v_en = 01, v_setp[1] unchanged.
REQ-038 Scenario 5: note-on with period 0 -> err pulses, v_en unchanged; all_off asserted during SCAN -> v_en = 0 and ev_ready = 1 on the next edge.
REQ-039 Scenario 6: rst_n low during COMMIT -> all outputs are at reset values; after release, ev_ready = 1 after one edge.
